uart_rx_ctrl: RTL and testbench



---
 rtl/uart_rx_ctrl_pkg.sv | 26 ++
 rtl/uart_rx_ctrl_rx_sync.sv | 21 ++
 rtl/uart_rx_ctrl.sv | 126 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// uart_rx_ctrl_pkg: state encodings, oversampling constants and the majority-vote helper for the UART receive path.
package uart_rx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int CNT_W      = $clog2(OVERSAMPLE);

    localparam logic [CNT_W-1:0] SAMP_A      = CNT_W'(7);
    localparam logic [CNT_W-1:0] SAMP_B      = CNT_W'(8);
    localparam logic [CNT_W-1:0] SAMP_C      = CNT_W'(9);
    localparam logic [CNT_W-1:0] STOP_DECIDE = CNT_W'(9);
    localparam logic [CNT_W-1:0] BIT_END     = CNT_W'(15);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_rx_sync.sv
// rx_sync: two-flop synchronizer for an asynchronous line that idles high, so both flops reset to 1.
module rx_sync (
    input  logic clkin,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 16x-oversampled UART receiver with majority-voted bits and one-cycle result pulses.
// Define UART_RX_PARITY_EN to insert a parity bit between the data bits and the stop bit.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    input  logic                 tick16,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bidx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rxs, s_a, s_b, s_c, vote;
    logic                 dv_d, fe_d;

    rx_sync u_sync (
        .clkin (clkin),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxs)
    );

    // The stop bit is decided at the third sample point, so the live sample stands in for s_c there.
    always_comb begin
        vote = maj3(s_a, s_b, (cnt == STOP_DECIDE) ? rxs : s_c);
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (tick16) begin
            case (state)
                IDLE:    state_n = rxs ? IDLE : START;
                START:   state_n = (cnt != BIT_END) ? START : (vote ? IDLE : DATA);
                DATA:    state_n = (cnt == BIT_END && bidx == LAST_BIT) ? AFTER_DATA : DATA;
`ifdef UART_RX_PARITY_EN
                PARITY:  state_n = (cnt == BIT_END) ? STOP : PARITY;
`endif
                STOP:    state_n = (cnt != STOP_DECIDE) ? STOP : (vote ? IDLE : BREAK);
                BREAK:   state_n = rxs ? IDLE : BREAK;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            bidx  <= '0;
            shreg <= '0;
            s_a   <= 1'b1;
            s_b   <= 1'b1;
            s_c   <= 1'b1;
        end else if (tick16) begin
            cnt <= (state == IDLE) ? '0 : cnt + 1'b1;
            if (cnt == SAMP_A) s_a <= rxs;
            if (cnt == SAMP_B) s_b <= rxs;
            if (cnt == SAMP_C) s_c <= rxs;
            if (state == START) bidx <= '0;
            if (state == DATA && cnt == BIT_END) begin
                shreg <= {vote, shreg[DATA_BITS-1:1]};
                bidx  <= bidx + 1'b1;
            end
        end
    end

    always_comb begin
        dv_d = tick16 && state == STOP && cnt == STOP_DECIDE && vote;
        fe_d = tick16 && state == STOP && cnt == STOP_DECIDE && !vote;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= dv_d;
            frame_err  <= fe_d;
            if (dv_d) data_out <= shreg;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (tick16 && state == PARITY && cnt == BIT_END) par_bit <= vote;
            parity_err <= dv_d && (par_bit != (^shreg ^ PARITY_ODD[0]));
        end
    end
`else
    assign parity_err = 1'b0 & PARITY_ODD[0];
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames driven tick by tick; a monitor checks each result pulse against a queue of expectations.
module tb_uart_rx_ctrl;

    typedef struct {
        bit         fe;
        logic [7:0] d;
        bit         pe;
    } exp_t;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick16 = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, frame_err, parity_err, busy;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY_ODD(0)) dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .tick16     (tick16),
        .rxd        (rxd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clkin = ~clkin;

    initial begin
        forever begin
            repeat (3) @(negedge clkin);
            tick16 = 1'b1;
            @(negedge clkin);
            tick16 = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, req);
        end
    endtask

    task automatic tick_wait();
        do @(posedge clkin); while (!tick16);
        #1;
    endtask

    task automatic hold(input logic level, input int n);
        rxd = level;
        repeat (n) tick_wait();
    endtask

    // glitch >= 0 forces the middle sample of that data bit high
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit with_par,
                              input logic par, input int glitch);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch) begin
                hold(d[i], 9);
                hold(1'b1, 1);
                hold(d[i], 6);
            end else begin
                hold(d[i], 16);
            end
        end
        if (with_par) hold(par, 16);
        hold(stop, 16);
    endtask

    task automatic expect_byte(input logic [7:0] d, input bit pe);
        exp_t e;
        e.fe = 1'b0;
        e.d  = d;
        e.pe = pe;
        q.push_back(e);
    endtask

    task automatic expect_ferr(input logic [7:0] held);
        exp_t e;
        e.fe = 1'b1;
        e.d  = held;
        e.pe = 1'b0;
        q.push_back(e);
    endtask

    always @(negedge clkin) begin
        if (rst_n && (data_valid || frame_err)) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: dv=%0b fe=%0b data_out=%02h", data_valid, frame_err, data_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_kind", {6'd0, data_valid, frame_err}, e.fe ? 8'h01 : 8'h02);
                chk("data_out", data_out, e.d);
                chk("parity_err", {7'd0, parity_err}, {7'd0, e.pe});
            end
        end
    end

    initial begin
        repeat (5) @(negedge clkin);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_data_valid", {7'd0, data_valid}, 8'h00);
        chk("rst_frame_err", {7'd0, frame_err}, 8'h00);
        chk("rst_parity_err", {7'd0, parity_err}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        rst_n = 1'b1;
        hold(1'b1, 20);

        expect_byte(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
        chk("busy_after_a5", {7'd0, busy}, 8'h00);
        hold(1'b1, 10);

        hold(1'b0, 3);
        chk("busy_glitch", {7'd0, busy}, 8'h01);
        hold(1'b1, 20);
        chk("busy_after_glitch", {7'd0, busy}, 8'h00);

        expect_ferr(8'hA5);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
        hold(1'b0, 40);
        chk("busy_in_break", {7'd0, busy}, 8'h01);
        hold(1'b1, 3);
        chk("busy_after_break", {7'd0, busy}, 8'h00);
        hold(1'b1, 20);

        expect_byte(8'h00, 1'b0);
        expect_byte(8'hFF, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 3);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, -1);
        hold(1'b1, 20);

        hold(1'b0, 16);
        for (int i = 0; i < 4; i++) hold(i[0] ? 1'b0 : 1'b1, 16);
        hold(1'b1, 5);
        rst_n = 1'b0;
        #1;
        chk("midrst_data_out", data_out, 8'h00);
        chk("midrst_busy", {7'd0, busy}, 8'h00);
        chk("midrst_valid", {7'd0, data_valid}, 8'h00);
        chk("midrst_ferr", {7'd0, frame_err}, 8'h00);
        repeat (5) @(negedge clkin);
        rxd = 1'b1;
        rst_n = 1'b1;
        hold(1'b1, 20);
        expect_byte(8'h55, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, -1);
        hold(1'b1, 20);

`ifdef UART_RX_PARITY_EN
        expect_byte(8'h07, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, -1);
        hold(1'b1, 20);
        expect_byte(8'h07, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1);
        hold(1'b1, 20);
`endif

        chk("pending_expectations", 8'(q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
